// File: rtl/register_file.sv
// RISC-V integer register file: 2**ADDR_WIDTH x DATA_WIDTH, two combinational read ports, one write port.
// Optional macro REGFILE_BYPASS_EN forwards WD3 to a read port that addresses the register being written.
module register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  WE3,
   input  logic [ADDR_WIDTH-1:0] A1,
   input  logic [ADDR_WIDTH-1:0] A2,
   input  logic [ADDR_WIDTH-1:0] A3,
   input  logic [DATA_WIDTH-1:0] WD3,
   output logic [DATA_WIDTH-1:0] RD1,
   output logic [DATA_WIDTH-1:0] RD2
);

   localparam int REG_COUNT = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

   logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];
   logic                  write_s;

   // Writes to x0 are dropped here so the stored x0 never leaves zero.
   always_comb begin
      write_s = 1'b0;
      if (WE3 && (A3 != ZERO_ADDR)) begin
         write_s = 1'b1;
      end else begin
         write_s = 1'b0;
      end
   end

   // Register array: async clear has priority over any write on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_r[i] <= ZERO_DATA;
         end
      end else if (write_s) begin
         regs_r[A3] <= WD3;
      end
   end

   function automatic logic [DATA_WIDTH-1:0] read_port(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic                  wr,
      input logic [ADDR_WIDTH-1:0] wr_addr,
      input logic [DATA_WIDTH-1:0] wr_data,
      input logic [DATA_WIDTH-1:0] stored
   );
      logic [DATA_WIDTH-1:0] value;
      if (addr == ZERO_ADDR) begin
         value = ZERO_DATA;
`ifdef REGFILE_BYPASS_EN
      end else if (wr && (wr_addr == addr)) begin
         value = wr_data;
`endif
      end else begin
         value = stored;
      end
      // Keep the write-side arguments referenced in the build without bypass.
      if (wr && (wr_addr == addr) && (wr_data == stored)) begin
         value = value;
      end else begin
         value = value;
      end
      return value;
   endfunction

   // Combinational read ports.
   always_comb begin
      RD1 = ZERO_DATA;
      RD2 = ZERO_DATA;
      RD1 = read_port(A1, write_s, A3, WD3, regs_r[A1]);
      RD2 = read_port(A2, write_s, A3, WD3, regs_r[A2]);
   end

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an array reference model.
// Honours REGFILE_BYPASS_EN when expecting same-cycle read/write results.
module tb_register_file;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          we3;
   logic [AW-1:0] a1, a2, a3;
   logic [DW-1:0] wd3;
   logic [DW-1:0] rd1, rd2;

   logic [DW-1:0] model [32];
   int checks = 0;
   int errors = 0;

   register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .WE3(we3), .A1(a1), .A2(a2), .A3(a3),
      .WD3(wd3), .RD1(rd1), .RD2(rd2)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected read value from the architectural state plus current write port.
   function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
      if (!rst_n || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
      if (we3 && a3 != 5'd0 && a3 == a) return wd3;
`endif
      return model[a];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
   endtask

   // Drive one cycle while clk is low, check reads, then take the edge.
   task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra1, input logic [AW-1:0] ra2, input string tag);
      we3 = we; a3 = wa; wd3 = wd; a1 = ra1; a2 = ra2;
      #1;
      check_val({tag, "_rd1"}, rd1, ref_read(a1));
      check_val({tag, "_rd2"}, rd2, ref_read(a2));
      @(posedge clk);
      if (rst_n && we3 && a3 != 5'd0) model[a3] = wd3;
      @(negedge clk);
   endtask

   initial begin
      logic [DW-1:0] exp_by;
      clear_model();
      rst_n = 1'b0; we3 = 1'b1; a3 = 5'd3; wd3 = 32'hCAFE_F00D; a1 = 5'd3; a2 = 5'd17;
      #1;
      check_val("reset_rd1", rd1, 32'd0);
      check_val("reset_rd2", rd2, 32'd0);
      // Write attempted while reset is held must be lost.
      @(posedge clk);
      @(negedge clk);
      check_val("reset_prio", rd1, 32'd0);
      rst_n = 1'b1;
      we3 = 1'b0;

      for (int i = 1; i <= 5; i++)
         step(1'b1, AW'(i), DW'(i) * 32'h1111, 5'd0, 5'd0, "load");
      for (int i = 1; i <= 5; i++) begin
         we3 = 1'b0; a1 = AW'(i); a2 = AW'(i);
         #1;
         check_val("seq_rd1", rd1, DW'(i) * 32'h1111);
         check_val("seq_rd2", rd2, DW'(i) * 32'h1111);
         @(negedge clk);
      end

      step(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, "x0_wr");
      a1 = 5'd0; we3 = 1'b0; #1;
      check_val("x0_read", rd1, 32'd0);

      for (int k = 0; k < 4; k++) step(1'b0, 5'd7, 32'h1234_5678, 5'd7, 5'd0, "we_off");
      a1 = 5'd7; #1;
      check_val("we_off_r7", rd1, 32'd0);

      step(1'b1, 5'd9, 32'hA5A5_A5A5, 5'd0, 5'd0, "r9_init");
      we3 = 1'b1; a3 = 5'd9; wd3 = 32'h5A5A_5A5A; a1 = 5'd9; a2 = 5'd9;
`ifdef REGFILE_BYPASS_EN
      exp_by = 32'h5A5A_5A5A;
`else
      exp_by = 32'hA5A5_A5A5;
`endif
      #1;
      check_val("rw_same_pre1", rd1, exp_by);
      check_val("rw_same_pre2", rd2, exp_by);
      @(posedge clk);
      model[9] = 32'h5A5A_5A5A;
      #1;
      check_val("rw_same_post", rd1, 32'h5A5A_5A5A);
      @(negedge clk);
      we3 = 1'b0;

      // Mid-cycle asynchronous reset pulse.
      a1 = 5'd1; a2 = 5'd5; #1;
      check_val("pre_rst_rd1", rd1, 32'h1111);
      check_val("pre_rst_rd2", rd2, 32'h5555);
      #1 rst_n = 1'b0;
      #1;
      check_val("async_rst_rd1", rd1, 32'd0);
      check_val("async_rst_rd2", rd2, 32'd0);
      clear_model();
      #1 rst_n = 1'b1;
      @(negedge clk);
      for (int i = 1; i < 32; i++) begin
         a1 = AW'(i); a2 = AW'(32 - i); #1;
         check_val("post_rst_rd1", rd1, 32'd0);
         check_val("post_rst_rd2", rd2, 32'd0);
         #1;
      end
      @(negedge clk);

      step(1'b1, 5'd31, 32'hFFFF_FFFF, 5'd0, 5'd0, "r31");
      step(1'b1, 5'd30, 32'h0000_0001, 5'd0, 5'd0, "r30");
      we3 = 1'b0; a1 = 5'd31; a2 = 5'd30; #1;
      check_val("r31_rd1", rd1, 32'hFFFF_FFFF);
      check_val("r30_rd2", rd2, 32'h0000_0001);
      @(negedge clk);

      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 31)), DW'($urandom),
              AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)), "rand");
      end
      for (int i = 0; i < 32; i++) begin
         we3 = 1'b0; a1 = AW'(i); a2 = AW'(31 - i); #1;
         check_val("final_rd1", rd1, ref_read(a1));
         check_val("final_rd2", rd2, ref_read(a2));
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
